// File: rtl/regfile_3w6r_if.sv
// Writeback/decode bundle of the 3-write/6-read register file.
// master = writeback + decode side, slave = register file.
interface regfile_3w6r_if #(
  parameter int DATA_W = 64,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
);
  logic              w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3;
  logic [ADDR_W-1:0] w2re_destpipe1, w2re_destpipe2, w2re_destpipe3;
  logic [DATA_W-1:0] w2re_datapipe1, w2re_datapipe2, w2re_datapipe3;

  logic [ADDR_W-1:0] d2r_srcApipe1, d2r_srcApipe2, d2r_srcApipe3;
  logic [ADDR_W-1:0] d2r_srcBpipe1, d2r_srcBpipe2, d2r_srcBpipe3;
  logic [DATA_W-1:0] r2d_dataApipe1, r2d_dataApipe2, r2d_dataApipe3;
  logic [DATA_W-1:0] r2d_dataBpipe1, r2d_dataBpipe2, r2d_dataBpipe3;

  logic              d2r_issuepipe1, d2r_issuepipe2, d2r_issuepipe3;
  logic [ADDR_W-1:0] d2r_issuedestpipe1, d2r_issuedestpipe2, d2r_issuedestpipe3;
  logic [NREG-1:0]   r2d_busy;

  modport master (
    output w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3,
    output w2re_destpipe1, w2re_destpipe2, w2re_destpipe3,
    output w2re_datapipe1, w2re_datapipe2, w2re_datapipe3,
    output d2r_srcApipe1, d2r_srcApipe2, d2r_srcApipe3,
    output d2r_srcBpipe1, d2r_srcBpipe2, d2r_srcBpipe3,
    output d2r_issuepipe1, d2r_issuepipe2, d2r_issuepipe3,
    output d2r_issuedestpipe1, d2r_issuedestpipe2, d2r_issuedestpipe3,
    input  r2d_dataApipe1, r2d_dataApipe2, r2d_dataApipe3,
    input  r2d_dataBpipe1, r2d_dataBpipe2, r2d_dataBpipe3,
    input  r2d_busy
  );

  modport slave (
    input  w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3,
    input  w2re_destpipe1, w2re_destpipe2, w2re_destpipe3,
    input  w2re_datapipe1, w2re_datapipe2, w2re_datapipe3,
    input  d2r_srcApipe1, d2r_srcApipe2, d2r_srcApipe3,
    input  d2r_srcBpipe1, d2r_srcBpipe2, d2r_srcBpipe3,
    input  d2r_issuepipe1, d2r_issuepipe2, d2r_issuepipe3,
    input  d2r_issuedestpipe1, d2r_issuedestpipe2, d2r_issuedestpipe3,
    output r2d_dataApipe1, r2d_dataApipe2, r2d_dataApipe3,
    output r2d_dataBpipe1, r2d_dataBpipe2, r2d_dataBpipe3,
    output r2d_busy
  );
endinterface

// File: rtl/regfile_3w6r.sv
// Architectural register file: NREG x DATA_W, 3 write / 6 read ports, reg0 = 0,
// plus pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write->read bypass.
module regfile_3w6r #(
  parameter int DATA_W = 64,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  regfile_3w6r_if.slave rf
);
  localparam int NWR = 3;
  localparam int NRD = 6;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;

  logic              wr_en    [NWR];
  logic [ADDR_W-1:0] wr_dest  [NWR];
  logic [DATA_W-1:0] wr_data  [NWR];
  logic              iss_en   [NWR];
  logic [ADDR_W-1:0] iss_dest [NWR];
  logic [ADDR_W-1:0] rd_addr  [NRD];
  logic [DATA_W-1:0] rd_data  [NRD];

  assign wr_en    = '{rf.w2r_wrpipe1, rf.w2r_wrpipe2, rf.w2r_wrpipe3};
  assign wr_dest  = '{rf.w2re_destpipe1, rf.w2re_destpipe2, rf.w2re_destpipe3};
  assign wr_data  = '{rf.w2re_datapipe1, rf.w2re_datapipe2, rf.w2re_datapipe3};
  assign iss_en   = '{rf.d2r_issuepipe1, rf.d2r_issuepipe2, rf.d2r_issuepipe3};
  assign iss_dest = '{rf.d2r_issuedestpipe1, rf.d2r_issuedestpipe2, rf.d2r_issuedestpipe3};
  assign rd_addr  = '{rf.d2r_srcApipe1, rf.d2r_srcBpipe1, rf.d2r_srcApipe2,
                      rf.d2r_srcBpipe2, rf.d2r_srcApipe3, rf.d2r_srcBpipe3};

  // Later pipes overwrite earlier ones, so pipe3 > pipe2 > pipe1 on a shared dest.
  // Only addresses 1..NREG-1 are matched: reg0 and out-of-range writes fall through.
  always_comb begin
    // NOTE: combinational blocks use blocking '='; defaults first so no latch is inferred.
    regs_d = regs_q;
    for (int i = 1; i < NREG; i++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_dest[p] == ADDR_W'(i)) regs_d[i] = wr_data[p];
      end
    end
    regs_d[0] = '0;
  end

  // Clears applied before sets: a fresh issue supersedes the retiring write.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_dest[p] == ADDR_W'(i)) busy_d[i] = 1'b0;
      end
      for (int p = 0; p < NWR; p++) begin
        if (iss_en[p] && iss_dest[p] == ADDR_W'(i)) busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the array is reset on purpose -- architectural state must read 0 after reset.
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read mux over 1..NREG-1; address 0 and out-of-range addresses read 0.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_data[r] = '0;
      for (int i = 1; i < NREG; i++) begin
        if (rd_addr[r] == ADDR_W'(i)) begin
          rd_data[r] = regs_q[i];
`ifdef REGFILE_BYPASS_EN
          for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_dest[p] == ADDR_W'(i)) rd_data[r] = wr_data[p];
          end
`else
`endif
        end
      end
    end
  end

  assign rf.r2d_dataApipe1 = rd_data[0];
  assign rf.r2d_dataBpipe1 = rd_data[1];
  assign rf.r2d_dataApipe2 = rd_data[2];
  assign rf.r2d_dataBpipe2 = rd_data[3];
  assign rf.r2d_dataApipe3 = rd_data[4];
  assign rf.r2d_dataBpipe3 = rd_data[5];
  assign rf.r2d_busy       = busy_q;
endmodule

// File: tb/tb_regfile_3w6r.sv
// Self-checking bench for regfile_3w6r: directed hazard/priority cases plus a random
// phase, all checked through a scoreboard queue against a behavioural model.
module tb_regfile_3w6r;
  localparam int DATA_W = 64;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_3w6r_if #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) rf ();
  regfile_3w6r #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf)
  );

  // Stimulus image (pipes 1..3; read ports A1,B1,A2,B2,A3,B3 = 0..5)
  logic              wren  [1:3];
  logic [ADDR_W-1:0] wdest [1:3];
  logic [DATA_W-1:0] wdat  [1:3];
  logic              isen  [1:3];
  logic [ADDR_W-1:0] isdst [1:3];
  logic [ADDR_W-1:0] srcs  [0:5];

  // Behavioural model
  logic [DATA_W-1:0] m [NREG];
  logic [NREG-1:0]   mb;

  // Scoreboard: sel 0..5 = read ports, 6 = busy vector
  typedef struct packed {
    logic [2:0]        sel;
    logic [DATA_W-1:0] exp;
  } exp_t;
  exp_t  sb_q  [$];
  string tag_q [$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] observe(input logic [2:0] sel);
    case (sel)
      3'd0:    return rf.r2d_dataApipe1;
      3'd1:    return rf.r2d_dataBpipe1;
      3'd2:    return rf.r2d_dataApipe2;
      3'd3:    return rf.r2d_dataBpipe2;
      3'd4:    return rf.r2d_dataApipe3;
      3'd5:    return rf.r2d_dataBpipe3;
      default: return {{(DATA_W-NREG){1'b0}}, rf.r2d_busy};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = (a == '0) ? '0 : m[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 1; p <= 3; p++)
      if (a != '0 && wren[p] && wdest[p] == a) v = wdat[p];
`endif
    return v;
  endfunction

  task automatic push(input string tag, input logic [2:0] sel, input logic [DATA_W-1:0] exp);
    sb_q.push_back('{sel: sel, exp: exp});
    tag_q.push_back(tag);
  endtask

  task automatic idle();
    reset = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      wren[p] = 1'b0; wdest[p] = '0; wdat[p] = '0; isen[p] = 1'b0; isdst[p] = '0;
    end
    for (int k = 0; k < 6; k++) srcs[k] = '0;
  endtask

  task automatic apply();
    rf.w2r_wrpipe1 = wren[1]; rf.w2r_wrpipe2 = wren[2]; rf.w2r_wrpipe3 = wren[3];
    rf.w2re_destpipe1 = wdest[1]; rf.w2re_destpipe2 = wdest[2]; rf.w2re_destpipe3 = wdest[3];
    rf.w2re_datapipe1 = wdat[1]; rf.w2re_datapipe2 = wdat[2]; rf.w2re_datapipe3 = wdat[3];
    rf.d2r_issuepipe1 = isen[1]; rf.d2r_issuepipe2 = isen[2]; rf.d2r_issuepipe3 = isen[3];
    rf.d2r_issuedestpipe1 = isdst[1]; rf.d2r_issuedestpipe2 = isdst[2];
    rf.d2r_issuedestpipe3 = isdst[3];
    rf.d2r_srcApipe1 = srcs[0]; rf.d2r_srcBpipe1 = srcs[1]; rf.d2r_srcApipe2 = srcs[2];
    rf.d2r_srcBpipe2 = srcs[3]; rf.d2r_srcApipe3 = srcs[4]; rf.d2r_srcBpipe3 = srcs[5];
  endtask

  task automatic model_edge();
    logic [NREG-1:0] nb;
    if (reset) begin
      for (int i = 0; i < NREG; i++) m[i] = '0;
      mb = '0;
    end else begin
      nb = mb;
      for (int p = 1; p <= 3; p++) if (wren[p]) nb[wdest[p]] = 1'b0;
      for (int p = 1; p <= 3; p++) if (isen[p]) nb[isdst[p]] = 1'b1;
      nb[0] = 1'b0;
      mb = nb;
      for (int p = 1; p <= 3; p++) if (wren[p] && wdest[p] != '0) m[wdest[p]] = wdat[p];
    end
  endtask

  // Drive, push model expectations, compare everything queued, then clock once.
  task automatic cycle(input string tag);
    exp_t e;
    string t;
    apply();
    #2;
    for (int k = 0; k < 6; k++) push({tag, "_rd"}, 3'(k), model_read(srcs[k]));
    push({tag, "_busy"}, 3'd6, {{(DATA_W-NREG){1'b0}}, mb});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check(t, observe(e.sel), e.exp);
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic randomize_inputs(input bit allow_reset);
    for (int p = 1; p <= 3; p++) begin
      wren[p]  = 1'($urandom_range(0, 1));
      wdest[p] = ADDR_W'($urandom_range(0, NREG - 1));
      wdat[p]  = {$urandom, $urandom};
      isen[p]  = 1'($urandom_range(0, 1));
      isdst[p] = ADDR_W'($urandom_range(0, NREG - 1));
    end
    for (int k = 0; k < 6; k++) srcs[k] = ADDR_W'($urandom_range(0, NREG - 1));
    reset = allow_reset && ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    apply();
    repeat (2) @(posedge clock);
    model_edge();
    #1;

    // 1: random traffic, then one reset edge clears everything
    for (int n = 0; n < 10; n++) begin
      randomize_inputs(1'b0);
      cycle("pre_rst");
    end
    idle();
    reset = 1'b1;
    cycle("rst_edge");
    idle();
    srcs = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd9, 4'd15};
    for (int k = 0; k < 6; k++) push("rst_rd0", 3'(k), '0);
    push("rst_busy0", 3'd6, '0);
    cycle("after_rst");

    // 2: write then read next cycle; write to reg0 ignored
    idle();
    wren[1] = 1'b1; wdest[1] = 4'd5; wdat[1] = 64'hA5A5;
    cycle("wr5");
    idle();
    srcs[2] = 4'd5;
    push("rd5_A2", 3'd2, 64'hA5A5);
    wren[1] = 1'b1; wdest[1] = 4'd0; wdat[1] = 64'hFFFF;
    cycle("wr0");
    idle();
    push("rd0_A1", 3'd0, '0);
    cycle("rd0");

    // 3: three pipes to reg7 on one edge, pipe3 wins
    wren = '{1'b1, 1'b1, 1'b1};
    wdest = '{4'd7, 4'd7, 4'd7};
    wdat = '{64'd1, 64'd2, 64'd3};
    cycle("wr7x3");
    idle();
    srcs[4] = 4'd7;
    push("prio_A3", 3'd4, 64'd3);
    cycle("rd7");

    // 4: scoreboard set, set-beats-clear, clear
    idle();
    isen[1] = 1'b1; isdst[1] = 4'd9;
    cycle("iss9");
    idle();
    push("busy9_set", 3'd6, 64'h0200);
    wren[2] = 1'b1; wdest[2] = 4'd9; wdat[2] = 64'h99;
    isen[3] = 1'b1; isdst[3] = 4'd9;
    cycle("wr_iss9");
    idle();
    push("busy9_hold", 3'd6, 64'h0200);
    wren[1] = 1'b1; wdest[1] = 4'd9; wdat[1] = 64'h77;
    cycle("wr9");
    idle();
    push("busy9_clr", 3'd6, 64'h0);
    cycle("chk9");

    // 5: same-cycle write/read of reg3
    idle();
    wren[1] = 1'b1; wdest[1] = 4'd3; wdat[1] = 64'h1234;
    srcs[5] = 4'd3;
`ifdef REGFILE_BYPASS_EN
    push("byp_B3", 3'd5, 64'h1234);
`else
    push("nobyp_B3", 3'd5, 64'h0);
`endif
    cycle("wr3");
    idle();
    srcs[5] = 4'd3;
    push("rd3_B3", 3'd5, 64'h1234);
    cycle("rd3");

    // 6: reset with busy=0F0E and a write in flight
    idle();
    isen = '{1'b1, 1'b1, 1'b1};
    isdst = '{4'd1, 4'd2, 4'd3};
    cycle("iss123");
    isdst = '{4'd9, 4'd10, 4'd11};
    cycle("iss9ab");
    idle();
    isen[1] = 1'b1; isdst[1] = 4'd8;
    cycle("iss8");
    idle();
    push("busy_0F0E", 3'd6, 64'h0F0E);
    reset = 1'b1;
    wren[1] = 1'b1; wdest[1] = 4'd12; wdat[1] = 64'hDEAD;
    isen[2] = 1'b1; isdst[2] = 4'd4;
    cycle("rst_inflight");
    idle();
    srcs[0] = 4'd12;
    push("rst_rd12", 3'd0, '0);
    push("rst_busy", 3'd6, '0);
    cycle("after_rst2");

    // Random phase, occasional reset
    for (int n = 0; n < 60; n++) begin
      randomize_inputs(1'b1);
      cycle("rand");
    end
    idle();
    cycle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
